// File: rtl/uart_tx_tick.sv
// uart_tx_tick: byte-serial UART transmitter driven by an external bit-period strobe.
// A small valid/ready byte FIFO decouples the upstream writer from frame timing;
// the serialiser emits start, DATA_BITS data bits (LSB first) and STOP_BITS stop
// bits, one bit per tick, and chains queued bytes back-to-back with no idle gap.

module uart_tx_tick #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          tick,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    // ------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LW  = AW + 1;
    localparam int unsigned BCW = $clog2(DATA_BITS + 1);
    localparam int unsigned SCW = $clog2(STOP_BITS + 1);

    localparam logic [LW-1:0]  LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [BCW-1:0] LAST_BIT   = BCW'(DATA_BITS - 1);
    localparam logic [SCW-1:0] STOP_LAST  = SCW'(STOP_BITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_STOP
    } state_e;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q;
    logic [AW-1:0]        rd_ptr_d;
    logic [LW-1:0]        level_q;
    logic [LW-1:0]        level_d;
    logic [DATA_BITS-1:0] head;
    logic                 push;
    logic                 pop;
    logic                 have_data;

    // ------------------------------------------------------------------
    // Serialiser state
    // ------------------------------------------------------------------
    state_e               state_q;
    state_e               state_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [BCW-1:0]       bit_cnt_q;
    logic [BCW-1:0]       bit_cnt_d;
    logic [SCW-1:0]       stop_cnt_q;
    logic [SCW-1:0]       stop_cnt_d;
    logic                 tx_q;
    logic                 tx_d;
    logic                 busy_q;
    logic                 busy_d;
    logic                 last_data;
    logic                 stop_done;

    // in_ready comes straight from the registered level so it never depends on in_valid.
    assign in_ready   = (level_q != LEVEL_FULL);
    assign push       = in_valid && in_ready;
    assign have_data  = (level_q != '0);
    assign head       = mem_q[rd_ptr_q];
    assign last_data  = (bit_cnt_q == LAST_BIT);
    assign stop_done  = (stop_cnt_q == STOP_LAST);

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_level = level_q;

    // FIFO data array: written on every accepted push, no reset needed.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // FIFO pointer and occupancy next-state; pointers wrap naturally (power-of-two depth).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO pointer and occupancy registers; reset discards any queued bytes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: transitions only on tick edges.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (have_data) begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (last_data) begin
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (stop_done) begin
                        state_d = have_data ? ST_DATA : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: line level, busy flag, shifter/counters and the FIFO pop request.
    // STOP counts the stop bits it drives; the extra tick after the last one either
    // reloads the shifter (back-to-back start bit) or returns the line to idle.
    always_comb begin
        pop        = 1'b0;
        tx_d       = tx_q;
        busy_d     = busy_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                    if (have_data) begin
                        pop        = 1'b1;
                        shift_d    = head;
                        tx_d       = 1'b0;
                        busy_d     = 1'b1;
                        bit_cnt_d  = '0;
                        stop_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    tx_d       = shift_q[0];
                    shift_d    = shift_q >> 1;
                    bit_cnt_d  = bit_cnt_q + BCW'(1);
                    stop_cnt_d = '0;
                end
                ST_STOP: begin
                    if (!stop_done) begin
                        tx_d       = 1'b1;
                        stop_cnt_d = stop_cnt_q + SCW'(1);
                    end else if (have_data) begin
                        pop        = 1'b1;
                        shift_d    = head;
                        tx_d       = 1'b0;
                        busy_d     = 1'b1;
                        bit_cnt_d  = '0;
                        stop_cnt_d = '0;
                    end else begin
                        tx_d   = 1'b1;
                        busy_d = 1'b0;
                    end
                end
                default: begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    // Serialiser datapath registers; reset forces the line idle immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
        end else begin
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_tick.sv
// Testbench for uart_tx_tick: two instances (1 and 2 stop bits), a serial-line
// monitor that reassembles frames and a scoreboard of expected frames.

module tb_uart_tx_tick;

    localparam int unsigned DB = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tick  = 1'b0;
    logic [7:0] in_data0 = '0;
    logic [7:0] in_data1 = '0;
    logic [1:0] in_valid = '0;
    logic [1:0] in_ready_w;
    logic [1:0] tx_w;
    logic [1:0] busy_w;
    logic [2:0] lvl0;
    logic [2:0] lvl1;
    logic       tick_at_edge = 1'b0;

    int tests = 0;
    int fails = 0;
    int tick_mode = 0;
    int tick_div = 0;
    int cyc = 0;

    logic [15:0] exp_q0 [$];
    logic [15:0] exp_q1 [$];

    bit          mon_in     [2];
    int          mon_idx    [2];
    logic [15:0] mon_bits   [2];
    int          busy_cnt   [2];
    int          first_busy [2];
    int          last_busy  [2];
    int          tx_low_cnt [2];

    uart_tx_tick #(.DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
        .clock(clock), .reset(reset), .tick(tick), .in_data(in_data0),
        .in_valid(in_valid[0]), .in_ready(in_ready_w[0]), .tx(tx_w[0]),
        .busy(busy_w[0]), .fifo_level(lvl0)
    );

    uart_tx_tick #(.DATA_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut2 (
        .clock(clock), .reset(reset), .tick(tick), .in_data(in_data1),
        .in_valid(in_valid[1]), .in_ready(in_ready_w[1]), .tx(tx_w[1]),
        .busy(busy_w[1]), .fifo_level(lvl1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) tick_at_edge <= tick;

    // Tick generator: 0 = held low, 1 = every 4th clock, 2 = held high, 3 = random.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            tick_div = (tick_div + 1) % 4;
            case (tick_mode)
                0:       tick = 1'b0;
                1:       tick = (tick_div == 0);
                2:       tick = 1'b1;
                default: tick = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    // Reference frame: bit 0 start (0), then data LSB first, then STOP ones.
    function automatic logic [15:0] make_frame(input logic [7:0] d, input int s);
        int unsigned stop_mask;
        stop_mask = (32'd1 << s) - 32'd1;
        return (16'(d) << 1) | 16'(stop_mask << (1 + DB));
    endfunction

    function automatic int frame_len(input int k);
        return (k == 0) ? 10 : 11;
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic finish_frame(input int k);
        logic [15:0] want;
        bit have;
        have = 1'b0;
        want = '0;
        if (k == 0) begin
            if (exp_q0.size() > 0) begin want = exp_q0.pop_front(); have = 1'b1; end
        end else begin
            if (exp_q1.size() > 0) begin want = exp_q1.pop_front(); have = 1'b1; end
        end
        tests++;
        if (!have) begin
            fails++;
            $display("FAIL frame%0d: got frame %h, required none queued", k, mon_bits[k]);
        end else if (mon_bits[k] !== want) begin
            fails++;
            $display("FAIL frame%0d: got bits %h, required %h", k, mon_bits[k], want);
        end
    endtask

    // Line monitor: one sample per bit period, reassembles frames and checks busy.
    initial begin
        for (int k = 0; k < 2; k++) begin
            mon_in[k] = 1'b0; mon_idx[k] = 0; mon_bits[k] = '0;
            busy_cnt[k] = 0; first_busy[k] = -1; last_busy[k] = -1; tx_low_cnt[k] = 0;
        end
        forever begin
            @(negedge clock);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (busy_w[k]) begin
                    busy_cnt[k]++;
                    if (first_busy[k] < 0) first_busy[k] = cyc;
                    last_busy[k] = cyc;
                end
                if (!reset && tx_w[k] == 1'b0) tx_low_cnt[k]++;
                if (reset) begin
                    mon_in[k]  = 1'b0;
                    mon_idx[k] = 0;
                end else if (tick_at_edge) begin
                    if (mon_in[k] && mon_idx[k] == frame_len(k)) begin
                        finish_frame(k);
                        mon_in[k] = 1'b0;
                    end
                    if (mon_in[k]) begin
                        mon_bits[k][mon_idx[k]] = tx_w[k];
                        mon_idx[k]++;
                    end else if (tx_w[k] == 1'b0) begin
                        mon_in[k]   = 1'b1;
                        mon_bits[k] = '0;
                        mon_idx[k]  = 1;
                    end
                    tests++;
                    if (busy_w[k] != mon_in[k]) begin
                        fails++;
                        $display("FAIL busy%0d: got %0b, required %0b at cycle %0d",
                                 k, busy_w[k], mon_in[k], cyc);
                    end
                end
            end
        end
    end

    task automatic clr_stats(input int k);
        busy_cnt[k] = 0; first_busy[k] = -1; last_busy[k] = -1; tx_low_cnt[k] = 0;
    endtask

    // Called #1 after a posedge; the byte is accepted on the next edge.
    task automatic push_byte(input int k, input logic [7:0] d);
        if (k == 0) in_data0 = d; else in_data1 = d;
        in_valid[k] = 1'b1;
        @(posedge clock);
        if (k == 0) exp_q0.push_back(make_frame(d, 1));
        else        exp_q1.push_back(make_frame(d, 2));
        #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_idle(input int k, input int maxc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clock);
            if (qsize(k) == 0 && !mon_in[k]) begin
                done = 1'b1;
                break;
            end
        end
        #1;
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL wait_idle%0d: got timeout after %0d cycles, required drain", k, maxc);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ml;
        int n;
        int k;
        // Reset state
        #1 reset = 1'b1;
        #2;
        check("rst_tx0", tx_w[0], 1);
        check("rst_busy0", busy_w[0], 0);
        check("rst_level0", lvl0, 0);
        check("rst_ready0", in_ready_w[0], 1);
        check("rst_tx1", tx_w[1], 1);
        check("rst_ready1", in_ready_w[1], 1);
        idle_cycles(3);
        @(negedge clock);
        #2 reset = 1'b0;
        tick_mode = 1;
        idle_cycles(4);

        // Single byte baseline
        clr_stats(0);
        push_byte(0, 8'hA5);
        wait_idle(0, 200);
        check("single_busy_clks", busy_cnt[0], 40);

        // Back-to-back frames
        clr_stats(0);
        push_byte(0, 8'h00);
        push_byte(0, 8'hFF);
        push_byte(0, 8'h55);
        wait_idle(0, 400);
        check("b2b_busy_clks", busy_cnt[0], 120);
        check("b2b_busy_span", last_busy[0] - first_busy[0] + 1, 120);

        // FIFO full with tick held low
        tick_mode = 0;
        idle_cycles(2);
        ml = 0;
        for (int i = 0; i < 6; i++) begin
            in_data0    = 8'h10 + 8'(i);
            in_valid[0] = 1'b1;
            check("full_ready", in_ready_w[0], (ml < 4) ? 1 : 0);
            check("full_level", lvl0, ml);
            @(posedge clock);
            if (ml < 4) begin
                exp_q0.push_back(make_frame(8'h10 + 8'(i), 1));
                ml++;
            end
            #1;
        end
        in_valid[0] = 1'b0;
        check("full_level_final", lvl0, 4);
        check("full_ready_final", in_ready_w[0], 0);
        tick_mode = 1;
        wait_idle(0, 400);
        check("full_drained_level", lvl0, 0);

        // Constant tick
        tick_mode = 2;
        idle_cycles(2);
        clr_stats(0);
        push_byte(0, 8'h3C);
        wait_idle(0, 100);
        check("const_busy_clks", busy_cnt[0], 10);

        // Two stop bits, back to back
        tick_mode = 1;
        idle_cycles(2);
        clr_stats(1);
        push_byte(1, 8'h01);
        push_byte(1, 8'h02);
        wait_idle(1, 300);
        check("stop2_busy_clks", busy_cnt[1], 88);
        check("stop2_busy_span", last_busy[1] - first_busy[1] + 1, 88);

        // Randomized bursts on both instances
        for (int b = 0; b < 8; b++) begin
            tick_mode = $urandom_range(1, 3);
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                k = $urandom_range(0, 1);
                push_byte(k, 8'($urandom));
                idle_cycles($urandom_range(0, 3));
            end
            wait_idle(0, 2000);
            wait_idle(1, 2000);
        end

        // Reset mid-frame with two bytes still queued
        tick_mode = 1;
        idle_cycles(2);
        push_byte(0, 8'hC3);
        push_byte(0, 8'h5A);
        push_byte(0, 8'h96);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(posedge clock);
                if (mon_in[0] && mon_idx[0] == 5) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("rst_mid_reached_bit3", seen, 1);
        end
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_tx", tx_w[0], 1);
        check("rst_mid_busy", busy_w[0], 0);
        check("rst_mid_level", lvl0, 0);
        exp_q0.delete();
        exp_q1.delete();
        idle_cycles(2);
        @(negedge clock);
        #2 reset = 1'b0;
        clr_stats(0);
        idle_cycles(60);
        check("rst_after_tx_low", tx_low_cnt[0], 0);
        check("rst_after_busy", busy_w[0], 0);
        check("rst_after_level", lvl0, 0);

        // New push after reset is transmitted normally
        push_byte(0, 8'h81);
        wait_idle(0, 200);
        check("left0", exp_q0.size(), 0);
        check("left1", exp_q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
